sd_note_loader: RTL and testbench
=================================

# sd_note_loader

Streams the note chart from the SD card into the game. Sits directly downstream of `sd_controller` in the SD clock domain. It issues 512-byte sector reads at consecutive addresses and packs the returned bytes into 32-bit note records. The records are buffered in a FIFO, and the note scheduler drains them through a valid/ready handshake.

## Interface
Parameters:
- `START_ADR`, 32'h0000_0000: byte address of the first sector. Must be a multiple of 512.
- `NUM_SECTORS`, 16: number of sectors per load, range 1..65535.
- `FIFO_DEPTH`, 256: FIFO depth in 32-bit words. Must be a power of 2 and at least 128.

Ports:
- `clk`  in  1: 25 MHz clock, shared with `sd_controller`.
- `reset`  in  1: asynchronous, active-high.
- `start`  in  1: one-cycle pulse that begins a load.
- `sd_ready`  in  1: `sd_controller` ready.
- `sd_byte_available`  in  1: `sd_controller` byte strobe. It may stay high for several cycles per byte.
- `sd_dout`  in  8: `sd_controller` read data.
- `sd_rd`  out  1: read request to `sd_controller`.
- `sd_adr`  out  32: sector byte address to `sd_controller`.
- `note_data`  out  32: head-of-FIFO note record.
- `note_valid`  out  1: `note_data` is valid.
- `note_ready`  in  1: consumer accepts `note_data`.
- `busy`  out  1: a load is in progress.
- `done`  out  1: all `NUM_SECTORS` sectors have been read.
- `fifo_count`  out  log2(FIFO_DEPTH)+1: number of words in the FIFO.

## Operation
- **States:** IDLE, WAIT_SPACE, ISSUE, READ, NEXT, DONE.
- **IDLE:** on `start`, load `sd_adr`=`START_ADR`, clear the sector counter, go to WAIT_SPACE.
- **WAIT_SPACE:** wait until `sd_ready`=1 and FIFO free space ≥ 128 words, then go to ISSUE.
  - This guard prevents FIFO overflow, because a sector read cannot be paused once started.
- **ISSUE:** drive `sd_rd`=1 until `sd_ready` is sampled 0, then clear the byte counter and go to READ.
- **READ:** on each rising edge of `sd_byte_available` (registered 0→1 transition), capture `sd_dout`.
  - Bytes pack big-endian: byte 4k goes to bits [31:24], byte 4k+3 to bits [7:0].
  - Each 4th byte writes one word to the FIFO.
  - After byte 511, go to NEXT.
- **NEXT:** increment the sector counter and add 512 to `sd_adr`.
  - If counter = `NUM_SECTORS`, go to DONE; otherwise go to WAIT_SPACE.
- **DONE:** hold `done`=1. `start` returns to the IDLE start action: readdress and clear `done`. The FIFO is not flushed.
- `start` in any state other than IDLE or DONE is ignored.
- `busy` = 1 in WAIT_SPACE, ISSUE, READ and NEXT.
- **FIFO:** synchronous, first-word-fall-through.
  - A pop occurs when `note_valid` & `note_ready` at a clock edge.
  - Push and pop in the same cycle leave `fifo_count` unchanged.
  - A push into a full FIFO cannot occur by construction; the bench asserts this.
  - Pop on empty has no effect.
- **Width rules:**
  - `sd_adr` arithmetic is modulo 2^32; wrap is allowed, no error.
  - Byte counter is 9 bits and the sector counter is 16 bits.
- **Reset mid-operation:** everything returns to reset values and the partial word is discarded. `sd_controller` shares `reset`, so no sector read is left half-open.

## Timing
- **Reset values:**
  - state IDLE
  - `sd_rd`=0
  - `sd_adr`=`START_ADR`
  - `note_valid`=0
  - `note_data`=0
  - `busy`=0
  - `done`=0
  - `fifo_count`=0
- **Start latency:** `start` at edge n gives `busy`=1 from n+1. If space and `sd_ready` allow, `sd_rd`=1 from n+2.
- **Byte capture:** a 0→1 transition seen at edge m captures `sd_dout` at edge m+1.
  - When that byte completes a word, the FIFO write happens at the same edge m+1.
  - `note_valid` rises at m+2 if the FIFO was empty.
- Holding `sd_byte_available` high for several cycles produces exactly one capture.
- **Pop:** `note_data` and `note_valid` reflect the next word in the cycle after a pop edge.
- **Back-to-back sectors:** NEXT takes exactly 1 cycle between the last byte of one sector and re-entering WAIT_SPACE.
- `done` rises 1 cycle after NEXT for the final sector.

## Test plan
- **Single sector:** `NUM_SECTORS`=1; the SD model returns bytes 0x00..0xFF,0x00..0xFF.
  - First `note_data`=32'h00010203.
  - Word 63=32'hFCFDFEFF.
  - 128 words total, then `done`=1 and `busy`=0.
- **Multi-sector addressing:** `START_ADR`=32'h0000_1000, `NUM_SECTORS`=3.
  - The model records addresses 0x1000, 0x1200, 0x1400 at each `sd_rd`.
  - Exactly 3 reads occur.
- **Backpressure:** `note_ready`=0 throughout, `NUM_SECTORS`=4, `FIFO_DEPTH`=256.
  - 2 sectors load and `fifo_count`=256.
  - The state holds in WAIT_SPACE with `sd_rd`=0.
  - Popping 128 words lets sector 3 issue.
- **Strobe width:** `sd_byte_available` held high 3 cycles per byte -> exactly 128 words per sector, with no duplicated bytes.
- **Reset mid-READ:** reset asserted after byte 200 of a sector.
  - All outputs return to reset values immediately.
  - A subsequent `start` reloads from `START_ADR` with an empty FIFO.
- **Simultaneous push/pop:** `note_ready`=1 while words are arriving -> `fifo_count` never exceeds 1 and word order is preserved.

Source files
------------

// File: rtl/sd_note_loader.sv
// sd_note_loader: reads consecutive SD sectors and buffers them as 32-bit big-endian note records
module sd_note_loader #(
    parameter logic [31:0] START_ADR   = 32'h0000_0000,
    parameter int          NUM_SECTORS = 16,
    parameter int          FIFO_DEPTH  = 256
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          sd_ready,
    input  logic                          sd_byte_available,
    input  logic [7:0]                    sd_dout,
    output logic                          sd_rd,
    output logic [31:0]                   sd_adr,
    output logic [31:0]                   note_data,
    output logic                          note_valid,
    input  logic                          note_ready,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] SPACE_LIM = (AW+1)'(FIFO_DEPTH - 128);
    localparam logic [2:0] IDLE = 3'd0, WAIT_SPACE = 3'd1, ISSUE = 3'd2, READ = 3'd3, NEXT = 3'd4, DONE = 3'd5;
    logic [2:0]    state_q, state_d;
    logic [31:0]   adr_q, adr_d;
    logic [15:0]   sec_q, sec_d;
    logic [8:0]    byte_q, byte_d;
    logic [23:0]   part_q, part_d;
    logic          avail_q, avail_prev_q;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q, rd_nxt;
    logic [AW:0]   cnt_q;
    logic [31:0]   data_q;
    logic          valid_q;
    logic          rise, push, pop;
    assign rise       = avail_q & ~avail_prev_q;
    assign push       = (state_q == READ) && rise && (byte_q[1:0] == 2'd3);
    assign pop        = valid_q & note_ready;
    assign rd_nxt     = rd_q + AW'(pop);
    assign sd_rd      = (state_q == ISSUE);
    assign sd_adr     = adr_q;
    assign busy       = (state_q == WAIT_SPACE) || (state_q == ISSUE) || (state_q == READ) || (state_q == NEXT);
    assign done       = (state_q == DONE);
    assign note_data  = data_q;
    assign note_valid = valid_q;
    assign fifo_count = cnt_q;
    // Load sequencer: only issues a sector when a whole sector fits, since reads cannot stall
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        sec_d   = sec_q;
        byte_d  = byte_q;
        part_d  = part_q;
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d = WAIT_SPACE;
                adr_d   = START_ADR;
                sec_d   = '0;
            end
            WAIT_SPACE: if (sd_ready && cnt_q <= SPACE_LIM) state_d = ISSUE;
            ISSUE: if (!sd_ready) begin
                state_d = READ;
                byte_d  = '0;
            end
            READ: if (rise) begin
                byte_d  = byte_q + 9'd1;
                part_d  = {part_q[15:0], sd_dout};
                state_d = (byte_q == 9'd511) ? NEXT : READ;
            end
            NEXT: begin
                sec_d   = sec_q + 16'd1;
                adr_d   = adr_q + 32'd512;
                state_d = (sec_q + 16'd1 == 16'(NUM_SECTORS)) ? DONE : WAIT_SPACE;
            end
            default: state_d = IDLE;
        endcase
    end
    // Sequencer state and byte-strobe edge detector
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            adr_q        <= START_ADR;
            sec_q        <= '0;
            byte_q       <= '0;
            part_q       <= '0;
            avail_q      <= 1'b0;
            avail_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            adr_q        <= adr_d;
            sec_q        <= sec_d;
            byte_q       <= byte_d;
            part_q       <= part_d;
            avail_q      <= sd_byte_available;
            avail_prev_q <= avail_q;
        end
    end
    // FIFO pointers and registered head; head only sees words written on earlier edges
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            wr_q    <= wr_q + AW'(push);
            rd_q    <= rd_nxt;
            cnt_q   <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
            valid_q <= (cnt_q - (AW+1)'(pop)) != '0;
            data_q  <= mem[rd_nxt];
        end
    end
    // FIFO storage; the completing byte joins the three buffered ones
    always_ff @(posedge clk) begin
        if (push) mem[wr_q] <= {part_q, sd_dout};
    end
endmodule

// File: tb/tb_sd_note_loader.sv
// tb_sd_note_loader: scoreboard bench with an SD controller model feeding sd_note_loader
module tb_sd_note_loader;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, note_ready = 1'b0;
    logic        sd_ready, sd_byte_available, sd_rd, note_valid, busy, done;
    logic [7:0]  sd_dout;
    logic [31:0] sd_adr, note_data;
    logic [8:0]  fifo_count;
    int          compared = 0, mism = 0;
    int          rd_idx = 0, bytes_sent = 0, strobe_w = 1, pops = 0, max_cnt = 0;
    logic [31:0] exp_q[$], got_q[$], adr_log[$];

    sd_note_loader #(.START_ADR(32'h0000_1000), .NUM_SECTORS(4), .FIFO_DEPTH(256)) dut (
        .clk(clk), .reset(reset), .start(start), .sd_ready(sd_ready),
        .sd_byte_available(sd_byte_available), .sd_dout(sd_dout), .sd_rd(sd_rd),
        .sd_adr(sd_adr), .note_data(note_data), .note_valid(note_valid),
        .note_ready(note_ready), .busy(busy), .done(done), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mism++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_sd_rd"}, 32'(sd_rd), 0);
        chk({tag, "_sd_adr"}, sd_adr, 32'h0000_1000);
        chk({tag, "_note_valid"}, 32'(note_valid), 0);
        chk({tag, "_note_data"}, note_data, 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_fifo_count"}, 32'(fifo_count), 0);
    endtask

    // SD controller model: one 512-byte sector per accepted request, bytes 16*read+i
    initial begin
        logic [31:0] w;
        logic [7:0]  b;
        sd_ready = 1'b1;
        sd_byte_available = 1'b0;
        sd_dout = 8'h00;
        w = '0;
        forever begin
            @(negedge clk);
            if (sd_rd && sd_ready && !reset) begin
                adr_log.push_back(sd_adr);
                sd_ready = 1'b0;
                repeat (2) @(posedge clk);
                for (int i = 0; i < 512; i++) begin
                    if (reset) break;
                    b = 8'(i + 16 * rd_idx);
                    #1 sd_dout = b;
                    sd_byte_available = 1'b1;
                    w = {w[23:0], b};
                    if (i % 4 == 3) exp_q.push_back(w);
                    bytes_sent = i + 1;
                    repeat (strobe_w) @(posedge clk);
                    #1 sd_byte_available = 1'b0;
                    repeat (2) @(posedge clk);
                end
                rd_idx++;
                #1 sd_ready = 1'b1;
                sd_byte_available = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted word
    always @(negedge clk) begin
        if (!reset) begin
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            if (fifo_count > 9'd256) begin
                compared++;
                mism++;
                $display("FAIL fifo_overflow: got %0d expected <= 256", fifo_count);
            end
            if (note_valid && note_ready) begin
                pops++;
                got_q.push_back(note_data);
                if (exp_q.size() == 0) begin
                    compared++;
                    mism++;
                    $display("FAIL sb_unexpected: got %h expected no word", note_data);
                end else chk("sb_word", note_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 check_reset_vals("rst");
        reset = 1'b0;
        // Load 1: consumer always ready, 1-cycle strobes
        note_ready = 1'b1;
        max_cnt = 0;
        pulse_start();
        chk("lat_busy", 32'(busy), 1);
        chk("lat_rd_early", 32'(sd_rd), 0);
        @(posedge clk);
        #1 chk("lat_rd", 32'(sd_rd), 1);
        for (int k = 0; k < 10000 && !done; k++) @(posedge clk);
        repeat (10) @(posedge clk);
        #1 chk("l1_done", 32'(done), 1);
        chk("l1_busy", 32'(busy), 0);
        chk("l1_reads", 32'(adr_log.size()), 4);
        chk("l1_adr0", adr_log[0], 32'h0000_1000);
        chk("l1_adr1", adr_log[1], 32'h0000_1200);
        chk("l1_adr2", adr_log[2], 32'h0000_1400);
        chk("l1_adr3", adr_log[3], 32'h0000_1600);
        chk("l1_words", 32'(got_q.size()), 512);
        chk("l1_word0", got_q[0], 32'h0001_0203);
        chk("l1_word63", got_q[63], 32'hFCFD_FEFF);
        chk("l1_word127", got_q[127], 32'hFCFD_FEFF);
        chk("l1_word128", got_q[128], 32'h1011_1213);
        chk("l1_max_count", 32'(max_cnt), 1);
        chk("l1_sb_empty", 32'(exp_q.size()), 0);
        // Load 2: backpressure with 3-cycle strobes, restarted from DONE
        adr_log.delete();
        got_q.delete();
        rd_idx = 0;
        strobe_w = 3;
        note_ready = 1'b0;
        max_cnt = 0;
        pulse_start();
        chk("l2_done_clr", 32'(done), 0);
        for (int k = 0; k < 12000 && fifo_count != 9'd256; k++) @(posedge clk);
        repeat (50) @(posedge clk);
        #1 chk("l2_full", 32'(fifo_count), 256);
        chk("l2_hold_rd", 32'(sd_rd), 0);
        chk("l2_hold_busy", 32'(busy), 1);
        chk("l2_reads_full", 32'(adr_log.size()), 2);
        pops = 0;
        note_ready = 1'b1;
        for (int k = 0; k < 2000 && pops < 128; k++) begin
            @(posedge clk);
            #1;
        end
        note_ready = 1'b0;
        chk("l2_pops", 32'(pops), 128);
        for (int k = 0; k < 200 && adr_log.size() < 3; k++) @(posedge clk);
        #1 chk("l2_reads_resume", 32'(adr_log.size()), 3);
        chk("l2_adr2", adr_log[2], 32'h0000_1400);
        note_ready = 1'b1;
        for (int k = 0; k < 20000 && !done; k++) @(posedge clk);
        repeat (10) @(posedge clk);
        #1 chk("l2_done", 32'(done), 1);
        chk("l2_words", 32'(got_q.size()), 512);
        chk("l2_word0", got_q[0], 32'h0001_0203);
        chk("l2_max_count", 32'(max_cnt), 256);
        chk("l2_sb_empty", 32'(exp_q.size()), 0);
        // Load 3: reset while reading the first sector
        adr_log.delete();
        rd_idx = 0;
        bytes_sent = 0;
        strobe_w = 1;
        pulse_start();
        for (int k = 0; k < 2000 && bytes_sent < 201; k++) @(posedge clk);
        chk("l3_reached_200", 32'(bytes_sent >= 201), 1);
        @(posedge clk);
        #1 reset = 1'b1;
        #1 check_reset_vals("midrst");
        repeat (5) @(posedge clk);
        exp_q.delete();
        #1 reset = 1'b0;
        // Load 4: clean reload after the reset
        adr_log.delete();
        got_q.delete();
        rd_idx = 0;
        pulse_start();
        chk("l4_busy", 32'(busy), 1);
        chk("l4_fifo_empty", 32'(fifo_count), 0);
        for (int k = 0; k < 10000 && !done; k++) @(posedge clk);
        repeat (10) @(posedge clk);
        #1 chk("l4_done", 32'(done), 1);
        chk("l4_reads", 32'(adr_log.size()), 4);
        chk("l4_adr0", adr_log[0], 32'h0000_1000);
        chk("l4_words", 32'(got_q.size()), 512);
        chk("l4_word0", got_q[0], 32'h0001_0203);
        chk("l4_sb_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end
endmodule
